// File: rtl/ifmap_row_assembler_pkg.sv
// Shared definitions for the ifmap row assembler: NoC packet layout, the ifmap
// packet type code and the two-phase assembly state.
package ifmap_row_assembler_pkg;

  localparam int PKT_W     = 32;
  localparam int RSV_BIT   = 31;
  localparam int TYPE_LSB  = 29;
  localparam int TYPE_W    = 2;
  localparam int DST_LSB   = 21;
  localparam int DST_W     = 8;
  localparam int HALF_LSB  = 13;
  localparam int HALF_W    = 8;
  localparam int DATA_LSB  = 0;
  localparam int DATA_W    = 13;

  localparam int LO_W      = 13;
  localparam int HI_W      = 12;
  localparam int ROW_W     = LO_W + HI_W;
  localparam int ROW_IDX_W = 5;

  localparam logic [TYPE_W-1:0] PKT_TYPE_IFMAP = 2'b01;
  localparam logic [HALF_W-1:0] HALF_LO        = 8'h00;
  localparam logic [HALF_W-1:0] HALF_HI        = 8'h01;

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } asm_state_e;

  // The hi packet contributes only its low twelve data bits; bit 12 is a
  // protocol-violation marker, not row content.
  function automatic logic [ROW_W-1:0] assemble_row(
    input logic [DATA_W-1:0] hi_data,
    input logic [LO_W-1:0]   lo_bits
  );
    return {hi_data[HI_W-1:0], lo_bits};
  endfunction

endpackage

// File: rtl/ifmap_row_assembler_if.sv
// Packet-in / row-out handshake bundle of the ifmap row assembler.
// slave is the assembler side, master the producer/consumer side.
interface ifmap_row_assembler_if #(
  parameter int WIDTH_I = 25
);
  import ifmap_row_assembler_pkg::*;

  logic [PKT_W-1:0]     in_pkt;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH_I-1:0]   out_row;
  logic [ROW_IDX_W-1:0] out_row_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic                 frame_done;
  logic                 err;

  modport slave (
    input  in_pkt,
    input  in_valid,
    output in_ready,
    output out_row,
    output out_row_idx,
    output out_valid,
    input  out_ready,
    output frame_done,
    output err
  );

  modport master (
    output in_pkt,
    output in_valid,
    input  in_ready,
    input  out_row,
    input  out_row_idx,
    input  out_valid,
    output out_ready,
    input  frame_done,
    input  err
  );

endinterface

// File: rtl/ifmap_row_assembler_row_fifo.sv
// Assembled-row buffer: power-of-two deep FIFO with valid/ready on both sides.
// Flags are registered so neither ready nor valid depends combinationally on the peer.
module row_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ready_q;
  logic             valid_q;
  logic             push_s;
  logic             pop_s;

  assign push_s = in_valid_i & ready_q;
  assign pop_s  = out_ready_i & valid_q;

  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
      valid_q <= (count_d != CW'(0));
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifmap_row_assembler.sv
// Assembles spike rows from lo/hi NoC packet pairs addressed to this node and
// buffers them, tagged with their frame row number, for the downstream consumer.
module ifmap_row_assembler
  import ifmap_row_assembler_pkg::*;
#(
  parameter int         WIDTH_I    = 25,
  parameter int         DEPTH_I    = 25,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] NODE_ADDR  = 8'h00
) (
  input logic                  clk,
  input logic                  rst_n,
  ifmap_row_assembler_if.slave bus
);

  localparam int ENTRY_W = WIDTH_I + ROW_IDX_W;

  asm_state_e           state_q;
  asm_state_e           state_d;
  logic [LO_W-1:0]      lo_q;
  logic [LO_W-1:0]      lo_d;
  logic [ROW_IDX_W-1:0] row_cnt_q;
  logic [ROW_IDX_W-1:0] row_cnt_d;
  logic                 err_q;
  logic                 err_d;
  logic                 frame_q;
  logic                 frame_d;

  logic                 accept_s;
  logic                 push_s;
  logic                 pkt_ok_s;
  logic                 fifo_ready_s;
  logic                 fifo_valid_s;
  logic [ENTRY_W-1:0]   push_entry_s;
  logic [ENTRY_W-1:0]   head_entry_s;
  logic                 rsv_s;
  logic [TYPE_W-1:0]    ptype_s;
  logic [DST_W-1:0]     dst_s;
  logic [HALF_W-1:0]    half_s;
  logic [DATA_W-1:0]    data_s;

  assign rsv_s    = bus.in_pkt[RSV_BIT];
  assign ptype_s  = bus.in_pkt[TYPE_LSB +: TYPE_W];
  assign dst_s    = bus.in_pkt[DST_LSB +: DST_W];
  assign half_s   = bus.in_pkt[HALF_LSB +: HALF_W];
  assign data_s   = bus.in_pkt[DATA_LSB +: DATA_W];

  // The reserved bit carries no meaning here; it is decoded only so the whole
  // packet is visibly consumed.
  assign accept_s = bus.in_valid & fifo_ready_s & (rsv_s | ~rsv_s);
  assign pkt_ok_s = (ptype_s == PKT_TYPE_IFMAP) && (dst_s == NODE_ADDR);

  assign push_entry_s = {row_cnt_q, WIDTH_I'(assemble_row(data_s, lo_q))};

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    row_cnt_d = row_cnt_q;
    push_s    = 1'b0;
    err_d     = 1'b0;
    frame_d   = 1'b0;

    if (accept_s) begin
      if (!pkt_ok_s) begin
        err_d = 1'b1;
      end else if (half_s == HALF_LO) begin
        // A repeated lo replaces the earlier one but is still flagged.
        lo_d = data_s[LO_W-1:0];
        case (state_q)
          WAIT_LO: state_d = WAIT_HI;
          WAIT_HI: err_d   = 1'b1;
          default: state_d = WAIT_LO;
        endcase
      end else if (half_s == HALF_HI) begin
        case (state_q)
          WAIT_LO: err_d = 1'b1;
          WAIT_HI: begin
            push_s  = 1'b1;
            err_d   = data_s[DATA_W-1];
            state_d = WAIT_LO;
          end
          default: state_d = WAIT_LO;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end else begin
      state_d = state_q;
    end

    if (push_s) begin
      if (row_cnt_q == ROW_IDX_W'(DEPTH_I - 1)) begin
        row_cnt_d = '0;
        frame_d   = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + ROW_IDX_W'(1);
        frame_d   = 1'b0;
      end
    end else begin
      row_cnt_d = row_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LO;
      lo_q      <= '0;
      row_cnt_q <= '0;
      err_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      row_cnt_q <= row_cnt_d;
      err_q     <= err_d;
      frame_q   <= frame_d;
    end
  end

  row_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (push_entry_s),
    .in_valid_i  (push_s),
    .in_ready_o  (fifo_ready_s),
    .out_data_o  (head_entry_s),
    .out_valid_o (fifo_valid_s),
    .out_ready_i (bus.out_ready)
  );

  assign bus.in_ready    = fifo_ready_s;
  assign bus.out_valid   = fifo_valid_s;
  assign bus.out_row     = head_entry_s[WIDTH_I-1:0];
  assign bus.out_row_idx = head_entry_s[ENTRY_W-1 -: ROW_IDX_W];
  assign bus.err         = err_q;
  assign bus.frame_done  = frame_q;

endmodule
